// File: rtl/spi_image_loader_pkg.sv
// Shared types, mode codes and width helpers for the serial image loader.
package spi_image_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_NEXT     = 3'd4,
        ST_FIN      = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    // Mode codes are produced at 8 bits and truncated to MODE_W by the user.
    localparam logic [7:0] MODE_IDLE = 8'd0;

    // Frame is {stop 0, data word, address}.
    function automatic int frame_w(input int data_w, input int addr_w);
        return 1 + data_w + addr_w;
    endfunction

    // Room for idle (0), one code per segment, and the all-ones RUN code.
    function automatic int mode_w(input int nseg);
        return $clog2(nseg + 2);
    endfunction

    // Segment select width, never narrower than one bit.
    function automatic int seg_w(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

    // RUN is all ones at the given mode width.
    function automatic logic [7:0] mode_run(input int mw);
        return 8'((1 << mw) - 1);
    endfunction

    // Segment k is tagged with mode code k+1.
    function automatic logic [7:0] mode_of(input int seg);
        return 8'(seg + 1);
    endfunction

endpackage

// File: rtl/spi_image_loader_shifter.sv
// Serialises one frame LSB first: sclk low for CLK_DIV cycles, then high for
// CLK_DIV cycles per bit; mosi only moves on the falling edge.
module spi_frame_shifter #(
    parameter int FRAME_W = 13,
    parameter int CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               run,
    input  logic [FRAME_W-1:0] frame,
    output logic               sclk,
    output logic               mosi,
    output logic               frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    logic [FRAME_W-1:0] sreg_r;
    logic [DIV_W-1:0]   div_r;
    logic [BIT_W-1:0]   bit_r;
    logic               sclk_r;
    logic               half_end_s;

    assign half_end_s = (div_r == DIV_W'(CLK_DIV - 1));
    // Falling edge of the last bit: the owner leaves SHIFT on this cycle.
    assign frame_done = run && sclk_r && half_end_s && (bit_r == BIT_W'(FRAME_W - 1));
    assign sclk       = sclk_r;
    assign mosi       = sreg_r[0];

    // Divider, half-period phase and shift register; clear forces lines low.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg_r <= '0;
            div_r  <= '0;
            bit_r  <= '0;
            sclk_r <= 1'b0;
        end else if (load) begin
            sreg_r <= frame;
            div_r  <= '0;
            bit_r  <= '0;
            sclk_r <= 1'b0;
        end else if (run) begin
            if (half_end_s) begin
                div_r <= '0;
                if (!sclk_r) begin
                    sclk_r <= 1'b1;
                end else begin
                    sclk_r <= 1'b0;
                    sreg_r <= {1'b0, sreg_r[FRAME_W-1:1]};
                    bit_r  <= bit_r + BIT_W'(1);
                end
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_image_loader.sv
// Serial image loader: host-written segment buffer streamed frame by frame
// to the processor's load port with ack, timeout and bounded retry.
module spi_image_loader
    import spi_image_loader_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NSEG        = 2,
    parameter int CLK_DIV     = 1,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       last_addr,
    input  logic                    wr_en,
    input  logic [seg_w(NSEG)-1:0]  wr_seg,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    ack_in,
    output logic                    sclk_out,
    output logic                    mosi_out,
    output logic [mode_w(NSEG)-1:0] mode_out,
    output logic                    busy,
    output logic                    done_out,
    output logic                    err_out
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int FRAME_W = frame_w(DATA_W, ADDR_W);
    localparam int MODE_W  = mode_w(NSEG);
    localparam int SEG_W   = seg_w(NSEG);
    localparam int IDX_W   = $clog2(NSEG * DEPTH);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [MODE_W-1:0] MODE_RUN = MODE_W'(mode_run(MODE_W));
    localparam logic [MODE_W-1:0] MODE_OFF = MODE_W'(MODE_IDLE);

    logic [DATA_W-1:0] mem_r [NSEG*DEPTH];

    state_t             state_r, state_nx;
    logic [SEG_W-1:0]   seg_r, seg_nx;
    logic [ADDR_W-1:0]  addr_r, addr_nx;
    logic [ADDR_W-1:0]  last_r, last_nx;
    logic [RETRY_W-1:0] retry_r, retry_nx;
    logic [TO_W-1:0]    to_r, to_nx;
    logic               setup_r, setup_nx;
    logic               acked_r, acked_nx;
    logic               start_q_r;

    logic               busy_nx, done_nx, err_nx;
    logic [MODE_W-1:0]  mode_nx;

    logic               wr_ok_s;
    logic [IDX_W-1:0]   wr_idx_s, rd_idx_s;
    logic [FRAME_W-1:0] frame_s;
    logic               sh_load_s, sh_run_s, sh_clear_s, frame_done_s;

    assign wr_ok_s  = wr_en && !busy && ({1'b0, wr_seg} < (SEG_W + 1)'(NSEG));
    assign wr_idx_s = IDX_W'(wr_seg) * IDX_W'(DEPTH) + IDX_W'(wr_addr);
    // The frame is built from the segment/address the FSM is about to send.
    assign rd_idx_s = IDX_W'(seg_nx) * IDX_W'(DEPTH) + IDX_W'(addr_nx);
    assign frame_s  = {1'b0, mem_r[rd_idx_s], addr_nx};

    assign sh_load_s  = (state_nx == ST_SETUP) && (state_r != ST_SETUP);
    assign sh_run_s   = (state_r == ST_SHIFT);
    assign sh_clear_s = !((state_nx == ST_SETUP) || (state_nx == ST_SHIFT));

    spi_frame_shifter #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (sh_clear_s),
        .load       (sh_load_s),
        .run        (sh_run_s),
        .frame      (frame_s),
        .sclk       (sclk_out),
        .mosi       (mosi_out),
        .frame_done (frame_done_s)
    );

    // Host buffer write port; deliberately not reset so images survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Next-state logic of the load sequencer.
    always_comb begin
        state_nx = state_r;
        seg_nx   = seg_r;
        addr_nx  = addr_r;
        last_nx  = last_r;
        retry_nx = retry_r;
        to_nx    = to_r;
        setup_nx = setup_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !start_q_r) begin
                    state_nx = ST_SETUP;
                    seg_nx   = '0;
                    addr_nx  = '0;
                    retry_nx = '0;
                    last_nx  = last_addr;
                    setup_nx = 1'b0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (setup_r) begin
                    state_nx = ST_SHIFT;
                    setup_nx = 1'b0;
                end else begin
                    setup_nx = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (frame_done_s) begin
                    state_nx = ST_WAIT_ACK;
                    to_nx    = '0;
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_in) begin
                    state_nx = ST_NEXT;
                    retry_nx = '0;
                end else if (to_r == TO_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_r == RETRY_W'(MAX_RETRY)) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_SETUP;
                        retry_nx = retry_r + RETRY_W'(1);
                        setup_nx = 1'b0;
                    end
                end else begin
                    to_nx = to_r + TO_W'(1);
                end
            end
            ST_NEXT: begin
                setup_nx = 1'b0;
                if (addr_r < last_r) begin
                    state_nx = ST_SETUP;
                    addr_nx  = addr_r + ADDR_W'(1);
                end else if (seg_r != SEG_W'(NSEG - 1)) begin
                    state_nx = ST_SETUP;
                    seg_nx   = seg_r + SEG_W'(1);
                    addr_nx  = '0;
                end else begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                if (!start) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_FIN;
                end
            end
            ST_ERR: begin
                if (!start) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_ERR;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        busy_nx  = (state_nx == ST_SETUP) || (state_nx == ST_SHIFT) ||
                   (state_nx == ST_WAIT_ACK) || (state_nx == ST_NEXT);
        done_nx  = (state_nx == ST_FIN);
        err_nx   = (state_nx == ST_ERR);
        // Once the processor acks RUN it is running; keep mode at idle.
        acked_nx = (state_nx == ST_FIN) && (state_r == ST_FIN) && (acked_r || ack_in);
        case (state_nx)
            ST_SETUP, ST_SHIFT: mode_nx = MODE_W'(mode_of(int'(seg_nx)));
            ST_FIN:             mode_nx = acked_nx ? MODE_OFF : MODE_RUN;
            default:            mode_nx = MODE_OFF;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            seg_r     <= '0;
            addr_r    <= '0;
            last_r    <= '0;
            retry_r   <= '0;
            to_r      <= '0;
            setup_r   <= 1'b0;
            acked_r   <= 1'b0;
            start_q_r <= 1'b0;
            busy      <= 1'b0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
            mode_out  <= MODE_OFF;
        end else begin
            state_r   <= state_nx;
            seg_r     <= seg_nx;
            addr_r    <= addr_nx;
            last_r    <= last_nx;
            retry_r   <= retry_nx;
            to_r      <= to_nx;
            setup_r   <= setup_nx;
            acked_r   <= acked_nx;
            start_q_r <= start;
            busy      <= busy_nx;
            done_out  <= done_nx;
            err_out   <= err_nx;
            mode_out  <= mode_nx;
        end
    end

endmodule

// File: tb/tb_spi_image_loader.sv
// Randomised scoreboard bench for spi_image_loader: a frame-level model
// queues the expected frames, a monitor decodes sclk/mosi and compares.
module tb_spi_image_loader;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 4;
    localparam int NSEG        = 2;
    localparam int CLK_DIV     = 2;
    localparam int ACK_TIMEOUT = 64;
    localparam int MAX_RETRY   = 3;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int FRAME_W     = 1 + DATA_W + ADDR_W;
    localparam int MODE_W      = 2;
    localparam int SHIFT_CYC   = FRAME_W * 2 * CLK_DIV;
    localparam int RUN_MODE    = (1 << MODE_W) - 1;
    localparam int MAX_WAIT    = 20000;

    typedef struct {
        int                 seg;
        int                 addr;
        logic [MODE_W-1:0]  mode;
        logic [FRAME_W-1:0] bits;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] last_addr;
    logic              wr_en;
    logic [0:0]        wr_seg;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ack_in;
    logic              sclk_out;
    logic              mosi_out;
    logic [MODE_W-1:0] mode_out;
    logic              busy;
    logic              done_out;
    logic              err_out;

    logic [DATA_W-1:0] mem_m [NSEG][DEPTH];
    exp_t              sb_q [$];
    int                checks = 0;
    int                passes = 0;
    int                ack_policy = 0;   // 0 ack every frame, 1 never, 2 skip first try
    bit                quiet_ok = 1'b1;

    spi_image_loader #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NSEG        (NSEG),
        .CLK_DIV     (CLK_DIV),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_addr (last_addr),
        .wr_en     (wr_en),
        .wr_seg    (wr_seg),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ack_in    (ack_in),
        .sclk_out  (sclk_out),
        .mosi_out  (mosi_out),
        .mode_out  (mode_out),
        .busy      (busy),
        .done_out  (done_out),
        .err_out   (err_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one frame for a given segment/address of the image.
    task automatic push_frame(input int s, input int a);
        exp_t              e;
        logic [31:0]       av;
        av     = a;
        e.seg  = s;
        e.addr = a;
        e.mode = MODE_W'(s + 1);
        e.bits = {1'b0, mem_m[s][a], av[ADDR_W-1:0]};
        sb_q.push_back(e);
    endtask

    // Reference model: the whole frame sequence a load should produce.
    task automatic expect_run(input int last, input int policy);
        bit first;
        first = 1'b1;
        if (policy == 1) begin
            for (int r = 0; r <= MAX_RETRY; r++) push_frame(0, 0);
        end else begin
            for (int s = 0; s < NSEG; s++) begin
                for (int a = 0; a <= last; a++) begin
                    push_frame(s, a);
                    if (policy == 2 && first) push_frame(s, a);
                    first = 1'b0;
                end
            end
        end
    endtask

    task automatic write_word(input int s, input int a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_seg  = 1'(s);
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic host_write(input int s, input int a, input logic [DATA_W-1:0] d);
        write_word(s, a, d);
        mem_m[s][a] = d;
    endtask

    // One complete load: queue expectations, start, wait for FIN/ERR, check.
    task automatic run_load(input int last, input int policy);
        int n;
        bit expect_err;
        expect_err = (policy == 1);
        expect_run(last, policy);
        ack_policy = policy;
        last_addr  = ADDR_W'(last);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        last_addr = ADDR_W'($urandom_range(DEPTH - 1, 0));
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (!(done_out || err_out) && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("run_completes", 32'(n < MAX_WAIT), 32'd1);
        chk("frames_all_seen", 32'(sb_q.size()), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done_out), 32'(!expect_err));
        chk("end_err", 32'(err_out), 32'(expect_err));
        chk("end_mode", 32'(mode_out), expect_err ? 32'd0 : 32'(RUN_MODE));
        repeat (10) @(posedge clk);
        #1;
        // start still high: FIN/ERR must hold; in FIN the processor has acked.
        chk("hold_state", 32'({done_out, err_out}), expect_err ? 32'd1 : 32'd2);
        chk("mode_after_hold", 32'(mode_out), 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_flags", 32'({busy, done_out, err_out}), 32'd0);
        chk("quiet_lines", 32'(quiet_ok), 32'd1);
        sb_q.delete();
    endtask

    // Monitor: decode frames from sclk rising edges and compare with the queue.
    initial begin : monitor
        logic [FRAME_W-1:0] shreg;
        logic [MODE_W-1:0]  fmode;
        int  nbits, seg_cyc, high_len;
        bit  timing_ok, prev_sclk, prev_mosi, in_seg;
        exp_t e;
        nbits = 0; seg_cyc = 0; high_len = 0; timing_ok = 1'b1;
        prev_sclk = 1'b0; prev_mosi = 1'b0; shreg = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0; seg_cyc = 0; high_len = 0; timing_ok = 1'b1;
                prev_sclk = 1'b0; prev_mosi = 1'b0;
            end else begin
                in_seg = (mode_out >= 1) && (mode_out <= NSEG);
                if (in_seg) begin
                    seg_cyc++;
                end else if (seg_cyc != 0) begin
                    chk("frame_cycles", 32'(seg_cyc), 32'(2 + SHIFT_CYC));
                    chk("sclk_timing", 32'(timing_ok), 32'd1);
                    seg_cyc = 0;
                    timing_ok = 1'b1;
                end
                if (!in_seg && (sclk_out || mosi_out)) quiet_ok = 1'b0;
                if (sclk_out && prev_sclk && (mosi_out != prev_mosi)) timing_ok = 1'b0;
                if (sclk_out && !prev_sclk) begin
                    high_len = 1;
                    if (nbits < FRAME_W) shreg[nbits] = mosi_out;
                    nbits++;
                    if (nbits == FRAME_W) begin
                        fmode = mode_out;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_frame", 32'(shreg), 32'hFFFF_FFFF);
                        end else begin
                            e = sb_q.pop_front();
                            chk($sformatf("frame_bits_s%0d_a%0d", e.seg, e.addr), 32'(shreg), 32'(e.bits));
                            chk($sformatf("frame_mode_s%0d_a%0d", e.seg, e.addr), 32'(fmode), 32'(e.mode));
                        end
                        nbits = 0;
                    end
                end else if (sclk_out) begin
                    high_len++;
                end else if (prev_sclk) begin
                    if (high_len != CLK_DIV) timing_ok = 1'b0;
                end
                prev_sclk = sclk_out;
                prev_mosi = mosi_out;
            end
        end
    end

    // Processor side: acknowledge frames per policy, and ack RUN once in FIN.
    initial begin : ack_driver
        logic [MODE_W-1:0] pm;
        int  tx_count;
        bit  fin_acked;
        pm = '0; tx_count = 0; fin_acked = 1'b0;
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) tx_count = 0;
            if (!done_out) fin_acked = 1'b0;
            if (!rst && pm >= 1 && pm <= NSEG && mode_out == '0) begin
                tx_count++;
                if (ack_policy == 0 || (ack_policy == 2 && tx_count > 1)) begin
                    repeat (2) @(negedge clk);
                    ack_in = 1'b1;
                    @(negedge clk);
                    ack_in = 1'b0;
                end
            end else if (!rst && done_out && !fin_acked) begin
                repeat (4) @(negedge clk);
                ack_in = 1'b1;
                @(negedge clk);
                ack_in = 1'b0;
                fin_acked = 1'b1;
            end
            pm = rst ? '0 : mode_out;
        end
    end

    // Stimulus sequence.
    initial begin : stimulus
        int n;
        rst = 1'b1; start = 1'b0; last_addr = '0;
        wr_en = 1'b0; wr_seg = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sclk", 32'(sclk_out), 32'd0);
        chk("rst_mosi", 32'(mosi_out), 32'd0);
        chk("rst_mode", 32'(mode_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);

        for (int s = 0; s < NSEG; s++)
            for (int a = 0; a < DEPTH; a++)
                host_write(s, a, DATA_W'($urandom));
        host_write(0, 3, 8'hA5);

        run_load(3, 0);                                  // eight frames
        run_load($urandom_range(DEPTH - 1, 0), 1);       // never acked -> ERR
        run_load(2, 2);                                  // one resend
        run_load(0, 0);                                  // one frame per segment
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++)
                host_write($urandom_range(NSEG - 1, 0), $urandom_range(DEPTH - 1, 0), DATA_W'($urandom));
            run_load($urandom_range(DEPTH - 1, 0), 0);
        end

        // Reset in the middle of SHIFT, after a write attempt while busy.
        ack_policy = 0;
        last_addr  = ADDR_W'(3);
        @(posedge clk); #1;
        start = 1'b1;
        n = 0;
        while (!sclk_out && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_shift", 32'(sclk_out), 32'd1);
        write_word(0, 0, ~mem_m[0][0]);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        chk("midrst_sclk", 32'(sclk_out), 32'd0);
        chk("midrst_mosi", 32'(mosi_out), 32'd0);
        chk("midrst_mode", 32'(mode_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        run_load(3, 0);                                  // pre-reset image intact

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_image_loader.md
Name: spi_image_loader

Overview:
Parametrised serial image loader for the tiny processor. It holds NSEG memory images (e.g. imem, dmem) in an internal buffer that the host writes, and shifts them out frame-by-frame over sclk_out/mosi_out. mode_out tags each frame with its segment. It waits for a per-frame acknowledge, with timeout and bounded retry, then signals run/done. It sits between the FPGA demo top (buttons/host) and the processor's serial load port.

Parameters:
DATA_W, 8, word width per memory entry
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words per segment
NSEG, 2, number of segments; segment k uses mode code k+1
CLK_DIV, 1, sclk half-period in clk cycles (>=1)
ACK_TIMEOUT, 64, clk cycles to wait for ack_in after a frame (>=1)
MAX_RETRY, 3, resends of one frame before error (>=0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  level; rising level in IDLE begins a load
last_addr  in  ADDR_W  last address sent per segment; sampled when the load starts
wr_en  in  1  buffer write strobe; ignored while busy
wr_seg  in  $clog2(NSEG) (min 1)  buffer write segment
wr_addr  in  ADDR_W  buffer write address
wr_data  in  DATA_W  buffer write data
ack_in  in  1  frame accepted by processor
sclk_out  out  1  serial clock, idles low
mosi_out  out  1  serial data
mode_out  out  MODE_W=$clog2(NSEG+2)  0 = idle, k+1 = segment k, all-ones = RUN
busy  out  1  high from the cycle after start is taken until FIN/ERR
done_out  out  1  high in FIN
err_out  out  1  high in ERR

Behaviour:
- Reset: state IDLE; sclk_out=0, mosi_out=0, mode_out=0, busy=0, done_out=0, err_out=0; counters cleared. Buffer contents are NOT reset. A reset mid-frame aborts immediately, with no partial-frame completion.
- Buffer write: NSEG*DEPTH x DATA_W registers. The write happens on a clk edge with wr_en=1 && !busy && wr_seg<NSEG.
- Frame: FRAME_W = 1+DATA_W+ADDR_W bits = {1'b0, word, addr}, sent LSB first (addr bits first).
- States: IDLE, SETUP, SHIFT, WAIT_ACK, NEXT, FIN, ERR.
- IDLE: start=1 -> SETUP. Clear seg=0, addr=0, retry=0; latch last_addr.
- SETUP: 2 cycles. mode_out=seg+1, sclk low, mosi = frame bit 0. Then -> SHIFT.
- SHIFT: each bit is one sclk period, low for CLK_DIV cycles then high for CLK_DIV cycles. mosi changes only while sclk is low, so data is stable on the rising edge. The bit index advances on the falling edge. After the falling edge of bit FRAME_W-1 -> WAIT_ACK. SHIFT lasts exactly FRAME_W*2*CLK_DIV cycles. mode_out=seg+1.
- WAIT_ACK: mode_out=0, sclk=0, mosi=0; the timeout counter runs.
  - ack_in=1 -> NEXT, retry cleared.
  - Timeout reached with retry<MAX_RETRY -> retry++, back to SETUP with the same frame.
  - Timeout reached with retry==MAX_RETRY -> ERR.
  - ack_in on the same cycle as the timeout counts as ack.
- NEXT: 1 cycle.
  - addr<last_addr -> addr++, SETUP.
  - addr==last_addr and seg<NSEG-1 -> seg++, addr=0, SETUP.
  - Otherwise -> FIN.
- FIN: done_out=1, busy=0, mode_out=RUN (all ones). When ack_in=1, mode_out=0 (processor running). start=0 -> IDLE.
- ERR: err_out=1, busy=0, mode_out=0. start=0 -> IDLE.
- mosi_out=0 and sclk_out=0 in every state except SETUP/SHIFT.
- start held high in IDLE after FIN/ERR never re-triggers; a new load needs start low then high.

Decomposition:
- Package spi_image_loader_pkg: state enum, MODE_IDLE/MODE_RUN constants, mode_of(seg) function, FRAME_W and MODE_W computation functions.
- Sub-module spi_frame_shifter: CLK_DIV divider, bit counter, frame shift register. Interface: load/frame in, sclk/mosi/frame_done out.
- Buffer, counters and FSM stay in the top.

Test Plan:
1. Defaults; write seg0 addr3=0xA5; last_addr=3; ack_in pulsed 2 cycles after each frame -> 8 frames. seg0/addr3 frame bits LSB-first = 1,1,0,0,1,0,1,0,0,1,0,1,0. Each frame is 26 clk of SHIFT. mode_out is 1 for seg0 frames and 2 for seg1 frames, then 3 with done_out=1.
2. CLK_DIV=3 -> sclk is low 3 and high 3 cycles; mosi never changes while sclk is high; SHIFT = 78 cycles.
3. ack_in never asserted, MAX_RETRY=3 -> exactly 4 transmissions of seg0/addr0, then err_out=1 and mode_out=0. start low -> IDLE.
4. ack_in withheld for the first try only -> one resend, then normal completion with no error.
5. last_addr=0, NSEG=2 -> exactly 2 frames (addr 0 of each segment), then FIN.
6. rst asserted mid-SHIFT -> next cycle sclk=0, mosi=0, mode_out=0, busy=0. wr_en during busy is ignored; buffer content survives rst; a rerun transmits the pre-reset data.
